sequenciador_movimentos: RTL



---
 rtl/sequenciador_pkg.sv | 35 +++
 rtl/sequenciador_movimentos_fila.sv | 77 +++++++
 rtl/sequenciador_movimentos.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sequenciador_pkg.sv
// Shared definitions for the move sequencer and the servo manager:
// move width, state encodings and move codes.
package sequenciador_pkg;

  localparam int MOVE_W = 3;

  localparam logic [2:0] EST_OCIOSO    = 3'd0;
  localparam logic [2:0] EST_LE        = 3'd1;
  localparam logic [2:0] EST_DISPARA   = 3'd2;
  localparam logic [2:0] EST_AGUARDA   = 3'd3;
  localparam logic [2:0] EST_INTERVALO = 3'd4;
  localparam logic [2:0] EST_FIM       = 3'd5;

  typedef enum logic [2:0] {
    OCIOSO    = EST_OCIOSO,
    LE        = EST_LE,
    DISPARA   = EST_DISPARA,
    AGUARDA   = EST_AGUARDA,
    INTERVALO = EST_INTERVALO,
    FIM       = EST_FIM
  } estado_t;

  typedef logic [MOVE_W-1:0] move_t;

  // Face turns as understood by the servo manager (_I = counter-clockwise).
  localparam move_t MOV_U   = 3'd0;
  localparam move_t MOV_U_I = 3'd1;
  localparam move_t MOV_R   = 3'd2;
  localparam move_t MOV_R_I = 3'd3;
  localparam move_t MOV_F   = 3'd4;
  localparam move_t MOV_F_I = 3'd5;
  localparam move_t MOV_D   = 3'd6;
  localparam move_t MOV_D_I = 3'd7;

endpackage

// File: rtl/sequenciador_movimentos_fila.sv
// fila_movimentos: synchronous first-word-fall-through FIFO of move codes
// with saturating occupancy count and sticky overflow flag.
module fila_movimentos
  import sequenciador_pkg::*;
#(
  parameter int PROFUNDIDADE = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            limpa,
  input  logic [MOVE_W-1:0]               dado_in,
  output logic [MOVE_W-1:0]               dado_out,
  output logic [$clog2(PROFUNDIDADE):0]   contagem,
  output logic                            cheio,
  output logic                            vazio,
  output logic                            overflow
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  logic [MOVE_W-1:0] mem_q [PROFUNDIDADE];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     contagem_q, contagem_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  assign cheio    = (contagem_q == CW'(PROFUNDIDADE));
  assign vazio    = (contagem_q == '0);
  assign push_ok  = push && !cheio && !limpa;
  assign pop_ok   = pop && !vazio && !limpa;
  assign contagem = contagem_q;
  assign overflow = overflow_q;
  assign dado_out = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    contagem_d = contagem_q;
    overflow_d = overflow_q;
    if (limpa) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      contagem_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && cheio) overflow_d = 1'b1;
      if (push_ok && !pop_ok)      contagem_d = contagem_q + 1'b1;
      else if (!push_ok && pop_ok) contagem_d = contagem_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      contagem_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      contagem_q <= contagem_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: emptiness is carried by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= dado_in;
  end

endmodule

// File: rtl/sequenciador_movimentos.sv
// Move sequencer: buffers move codes and plays them one by one to the servo
// manager. Define SEQUENCIADOR_DB_ESTADO_EN to expose the state on db_estado.
module sequenciador_movimentos
  import sequenciador_pkg::*;
#(
  parameter int PROFUNDIDADE     = 32,
  parameter int INTERVALO_CICLOS = 5000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          carrega,
  input  logic [2:0]                    move_in,
  input  logic                          limpa,
  input  logic                          iniciar_seq,
  input  logic                          pronto_servos,
  output logic                          iniciar_servos,
  output logic [2:0]                    move_servos,
  output logic                          ocupado,
  output logic                          fim_seq,
  output logic                          vazio,
  output logic                          cheio,
  output logic                          overflow,
  output logic [$clog2(PROFUNDIDADE):0] contagem
`ifdef SEQUENCIADOR_DB_ESTADO_EN
  ,
  output logic [2:0]                    db_estado
`endif
);

  localparam int IW = (INTERVALO_CICLOS > 1) ? $clog2(INTERVALO_CICLOS) : 1;
  localparam logic [IW-1:0] INT_ULTIMO =
    IW'((INTERVALO_CICLOS > 0) ? INTERVALO_CICLOS - 1 : 0);

  estado_t       estado_q, estado_d;
  logic [IW-1:0] cont_q, cont_d;
  move_t         move_q, move_d;
  logic          iniciar_servos_q, iniciar_servos_d;
  logic          fim_seq_q, fim_seq_d;
  logic          ocupado_q, ocupado_d;

  logic          fila_pop, fila_limpa, fila_vazio;
  move_t         fila_dado;

  fila_movimentos #(
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fila (
    .clock    (clock),
    .reset    (reset),
    .push     (carrega),
    .pop      (fila_pop),
    .limpa    (fila_limpa),
    .dado_in  (move_in),
    .dado_out (fila_dado),
    .contagem (contagem),
    .cheio    (cheio),
    .vazio    (fila_vazio),
    .overflow (overflow)
  );

  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    move_d     = move_q;
    fila_pop   = 1'b0;
    fila_limpa = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (iniciar_seq)  estado_d = fila_vazio ? FIM : LE;
        else if (limpa)   fila_limpa = 1'b1;
      end
      LE: begin
        fila_pop = 1'b1;
        move_d   = fila_dado;
        estado_d = DISPARA;
      end
      DISPARA: estado_d = AGUARDA;
      AGUARDA: begin
        if (pronto_servos) begin
          if (INTERVALO_CICLOS == 0) begin
            estado_d = fila_vazio ? FIM : LE;
          end else begin
            estado_d = INTERVALO;
            cont_d   = '0;
          end
        end
      end
      INTERVALO: begin
        if (cont_q == INT_ULTIMO) estado_d = fila_vazio ? FIM : LE;
        else                      cont_d = cont_q + 1'b1;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    // Pulses follow the state by one cycle; ocupado tracks the state itself.
    iniciar_servos_d = (estado_q == DISPARA);
    fim_seq_d        = (estado_q == FIM);
    ocupado_d        = (estado_d != OCIOSO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q         <= OCIOSO;
      cont_q           <= '0;
      move_q           <= MOV_U;
      iniciar_servos_q <= 1'b0;
      fim_seq_q        <= 1'b0;
      ocupado_q        <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      cont_q           <= cont_d;
      move_q           <= move_d;
      iniciar_servos_q <= iniciar_servos_d;
      fim_seq_q        <= fim_seq_d;
      ocupado_q        <= ocupado_d;
    end
  end

  assign iniciar_servos = iniciar_servos_q;
  assign move_servos    = move_q;
  assign ocupado        = ocupado_q;
  assign fim_seq        = fim_seq_q;
  assign vazio          = fila_vazio;

`ifdef SEQUENCIADOR_DB_ESTADO_EN
  assign db_estado = estado_q;
`endif

endmodule
